// File: rtl/input_debouncer.sv
// input_debouncer: per-channel 2-flop synchroniser plus counter FSM debouncer.
// Each channel provides a stable level, one-cycle rise/fall pulses and a press-toggle bit.
module input_debouncer #(
  parameter int N_INPUTS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] raw_in,
  output logic [N_INPUTS-1:0] level,
  output logic [N_INPUTS-1:0] rise,
  output logic [N_INPUTS-1:0] fall,
  output logic [N_INPUTS-1:0] toggle
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {ST_LO, ST_WHI, ST_HI, ST_WLO} state_t;
  logic [N_INPUTS-1:0] r_s1, r_s2;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw_in;
      r_s2 <= r_s1;
    end
  end
  for (genvar g = 0; g < N_INPUTS; g++) begin : g_ch
    state_t r_st, w_st;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic r_level, r_rise, r_fall, r_toggle;
    logic w_rise, w_fall, w_want;
    assign w_want = (r_st == ST_WHI);
    // Waiting states share logic: w_want is the value that must persist to be accepted.
    always_comb begin
      w_st   = r_st;
      w_cnt  = r_cnt;
      w_rise = 1'b0;
      w_fall = 1'b0;
      case (r_st)
        ST_LO: if (r_s2[g]) begin
          w_st  = ST_WHI;
          w_cnt = CNT_W'(1);
        end
        ST_HI: if (!r_s2[g]) begin
          w_st  = ST_WLO;
          w_cnt = CNT_W'(1);
        end
        default: begin
          if (r_s2[g] != w_want) begin
            w_st  = w_want ? ST_LO : ST_HI;
            w_cnt = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_st   = w_want ? ST_HI : ST_LO;
            w_cnt  = '0;
            w_rise = w_want;
            w_fall = !w_want;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        r_st     <= ST_LO;
        r_cnt    <= '0;
        r_level  <= 1'b0;
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_toggle <= 1'b0;
      end else begin
        r_st     <= w_st;
        r_cnt    <= w_cnt;
        r_rise   <= w_rise;
        r_fall   <= w_fall;
        r_level  <= w_rise | (r_level & ~w_fall);
        r_toggle <= r_toggle ^ w_rise;
      end
    end
    assign level[g]  = r_level;
    assign rise[g]   = r_rise;
    assign fall[g]   = r_fall;
    assign toggle[g] = r_toggle;
  end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed checks of input_debouncer with DEBOUNCE_CYCLES=4 (latency 6 edges).
module tb_input_debouncer;
  localparam int N = 4;
  localparam int LAT = 6;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] raw_in, level, rise, fall, toggle;
  int n_cmp = 0;
  int n_err = 0;

  input_debouncer #(.N_INPUTS(N), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .level(level), .rise(rise), .fall(fall), .toggle(toggle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel ch just changed raw to 'to'; check level/rise/fall for n edges.
  task automatic watch(input int ch, input int n, input logic to);
    for (int i = 1; i <= n; i++) begin
      tick();
      check($sformatf("ch%0d_level_e%0d", ch, i), 32'(level[ch]), 32'(i >= LAT ? to : !to));
      check($sformatf("ch%0d_rise_e%0d", ch, i), 32'(rise[ch]), 32'(to && i == LAT));
      check($sformatf("ch%0d_fall_e%0d", ch, i), 32'(fall[ch]), 32'(!to && i == LAT));
    end
  endtask

  initial begin
    reset = 1'b1;
    raw_in = '0;
    tick();
    tick();
    check("reset_outputs", {level, rise, fall, toggle}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle_c%0d", i), {level, rise, fall, toggle}, 32'h0);
    end
    // Clean press on ch0.
    raw_in[0] = 1'b1;
    watch(0, 9, 1'b1);
    check("ch0_toggle", 32'(toggle[0]), 32'h1);
    // Ch1 high for 3 cycles only: rejected.
    raw_in[1] = 1'b1;
    tick();
    tick();
    tick();
    raw_in[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("ch1_glitch_c%0d", i), {level[1], rise[1], fall[1], toggle[1]}, 32'h0);
    end
    check("ch0_still_high", 32'(level[0]), 32'h1);
    // Ch2 bounce 1,0,1,0 then held 1.
    for (int i = 0; i < 4; i++) begin
      raw_in[2] = (i % 2 == 0);
      tick();
      check($sformatf("ch2_bounce_c%0d", i), {level[2], rise[2]}, 32'h0);
    end
    raw_in[2] = 1'b1;
    watch(2, 10, 1'b1);
    check("ch2_toggle", 32'(toggle[2]), 32'h1);
    // Ch3 press/release twice.
    raw_in[3] = 1'b1;
    watch(3, 12, 1'b1);
    check("ch3_toggle_p1", 32'(toggle[3]), 32'h1);
    raw_in[3] = 1'b0;
    watch(3, 12, 1'b0);
    check("ch3_toggle_r1", 32'(toggle[3]), 32'h1);
    raw_in[3] = 1'b1;
    watch(3, 12, 1'b1);
    check("ch3_toggle_p2", 32'(toggle[3]), 32'h0);
    raw_in[3] = 1'b0;
    watch(3, 12, 1'b0);
    check("ch3_toggle_r2", 32'(toggle[3]), 32'h0);
    check("other_toggles", 32'(toggle), 32'h5);
    // Reset mid-count on ch0.
    raw_in = '0;
    reset = 1'b1;
    tick();
    tick();
    check("reset2_outputs", {level, rise, fall, toggle}, 32'h0);
    reset = 1'b0;
    raw_in[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("ch0_precount_e%0d", i), {level, rise, fall}, 32'h0);
    end
    reset = 1'b1;
    tick();
    tick();
    check("ch0_midreset", {level, rise, fall, toggle}, 32'h0);
    reset = 1'b0;
    watch(0, 9, 1'b1);
    check("ch0_toggle_after_reset", 32'(toggle), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
